junction_phase_scheduler: RTL and testbench

- Timing and sequencing master for the highway/country-road junction.
- Owns the seconds prescaler and the per-phase countdown.
- Latches the country-road vehicle sensor and issues single-cycle time_out pulses to the country-road and highway light controllers, so every controller steps through the same 4-phase sequence in lockstep.
- Exports its phase and remaining time for display and debug.

---
 rtl/junction_phase_scheduler.sv | 100 ++++++++++
 tb/tb_junction_phase_scheduler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/junction_phase_scheduler.sv
// junction_phase_scheduler: seconds prescaler, per-phase countdown and
// time_out strobe generator keeping all junction light controllers in lockstep.
`default_nettype none

module junction_phase_scheduler #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned CNT_W    = 6,
  parameter int unsigned HW_MIN_T = 10,
  parameter int unsigned YEL_T    = 3,
  parameter int unsigned CR_GRN_T = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sensor,
  input  logic             hold,
  output logic             sensor_req,
  output logic             time_out,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] remaining
);

  localparam int unsigned    PS_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    P0_HW_GRN = 2'd0,
    P1_HW_YEL = 2'd1,
    P2_CR_GRN = 2'd2,
    P3_CR_YEL = 2'd3
  } phase_e;

  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [PS_W-1:0]  presc_q, presc_d;
  logic             time_out_q, time_out_d;
  logic             sensor_req_q, sensor_req_d;
  logic             run, tick, expired;

  function automatic logic [CNT_W-1:0] duration(input phase_e p);
    case (p)
      P0_HW_GRN: duration = CNT_W'(HW_MIN_T);
      P2_CR_GRN: duration = CNT_W'(CR_GRN_T);
      default:   duration = CNT_W'(YEL_T);
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q      <= P0_HW_GRN;
      remaining_q  <= CNT_W'(HW_MIN_T);
      presc_q      <= '0;
      time_out_q   <= 1'b0;
      sensor_req_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      remaining_q  <= remaining_d;
      presc_q      <= presc_d;
      time_out_q   <= time_out_d;
      sensor_req_q <= sensor_req_d;
    end
  end

  always_comb begin
    // Timing stalls once the countdown is exhausted; only an advance restarts it.
    run          = !hold && (remaining_q != '0);
    tick         = run && (presc_q == PS_LAST);
    expired      = (remaining_q == '0) && ((phase_q != P0_HW_GRN) || sensor_req_q);

    phase_d      = phase_q;
    remaining_d  = remaining_q;
    presc_d      = presc_q;
    sensor_req_d = sensor_req_q | (sensor && (phase_q == P0_HW_GRN));
    time_out_d   = expired && !hold && !time_out_q;

    if (run) begin
      presc_d = tick ? '0 : presc_q + PS_W'(1);
    end
    if (tick) begin
      remaining_d = remaining_q - CNT_W'(1);
    end

    // Advance on the edge that closes the strobe cycle, regardless of hold.
    if (time_out_q) begin
      phase_d     = phase_e'(phase_q + 2'd1);
      remaining_d = duration(phase_d);
      presc_d     = '0;
      if (phase_q == P0_HW_GRN) begin
        sensor_req_d = 1'b0;
      end
    end
  end

  assign phase      = phase_q;
  assign remaining  = remaining_q;
  assign time_out   = time_out_q;
  assign sensor_req = sensor_req_q;

endmodule

`default_nettype wire

// File: tb/tb_junction_phase_scheduler.sv
// tb_junction_phase_scheduler: directed timing scenarios plus random sensor/hold
// traffic, checked against a behavioural phase model and fixed cycle numbers.
`default_nettype none

module tb_junction_phase_scheduler;

  localparam int TICK_DIV = 4;
  localparam int CNT_W    = 6;
  localparam int HW_MIN_T = 3;
  localparam int YEL_T    = 2;
  localparam int CR_GRN_T = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sensor = 1'b0;
  logic             hold = 1'b0;
  logic             sensor_req;
  logic             time_out;
  logic [1:0]       phase;
  logic [CNT_W-1:0] remaining;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_idx;
  bit saw_to;

  // Behavioural model state
  int m_phase, m_rem, m_pre;
  bit m_to, m_req;

  junction_phase_scheduler #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W),
    .HW_MIN_T (HW_MIN_T),
    .YEL_T    (YEL_T),
    .CR_GRN_T (CR_GRN_T)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sensor     (sensor),
    .hold       (hold),
    .sensor_req (sensor_req),
    .time_out   (time_out),
    .phase      (phase),
    .remaining  (remaining)
  );

  always #5 clk = ~clk;

  function automatic int dur(input int p);
    if (p == 0) return HW_MIN_T;
    if (p == 2) return CR_GRN_T;
    return YEL_T;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (edge %0d): observed %0d expected %0d", tag, edge_idx, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_rem = HW_MIN_T; m_pre = 0; m_to = 0; m_req = 0;
  endtask

  task automatic model_edge(input bit s, input bit h);
    bit expd, nxt_to;
    expd   = (m_rem == 0) && ((m_phase != 0) || m_req);
    nxt_to = expd && !h && !m_to;
    if (m_to) begin
      if (m_phase == 0) m_req = 0;
      m_phase = (m_phase + 1) % 4;
      m_rem   = dur(m_phase);
      m_pre   = 0;
    end else begin
      if (s && m_phase == 0) m_req = 1;
      if (!h && m_rem > 0) begin
        m_pre = m_pre + 1;
        if (m_pre == TICK_DIV) begin
          m_pre = 0;
          m_rem = m_rem - 1;
        end
      end
    end
    m_to = nxt_to;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_phase"}, 32'(phase), 32'(m_phase));
    chk({tag, "_rem"},   32'(remaining), 32'(m_rem));
    chk({tag, "_to"},    32'(time_out), 32'(m_to));
    chk({tag, "_req"},   32'(sensor_req), 32'(m_req));
  endtask

  task automatic step(input bit s, input bit h, input string tag);
    sensor = s;
    hold   = h;
    @(posedge clk);
    edge_idx++;
    model_edge(s, h);
    #1;
    if (time_out === 1'b1) saw_to = 1;
    check_model(tag);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    sensor = 1'b0;
    hold   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_model("rst");
    #2;
    rst_n    = 1'b1;
    edge_idx = -1;
    saw_to   = 0;
  endtask

  // First P0 with the sensor held high from reset release.
  task automatic run_p0(input string tag);
    for (int i = 0; i < 14; i++) begin
      step(1'b1, 1'b0, tag);
      if (edge_idx == 0)  chk({tag, "_req_c1"}, 32'(sensor_req), 32'd1);
      if (edge_idx == 2)  chk({tag, "_rem_c3"}, 32'(remaining), 32'd3);
      if (edge_idx == 3)  chk({tag, "_rem_2"},  32'(remaining), 32'd2);
      if (edge_idx == 7)  chk({tag, "_rem_1"},  32'(remaining), 32'd1);
      if (edge_idx == 11) chk({tag, "_rem_0"},  32'(remaining), 32'd0);
      if (edge_idx == 11) chk({tag, "_to_c12"}, 32'(time_out), 32'd0);
      if (edge_idx == 12) chk({tag, "_to_c13"}, 32'(time_out), 32'd1);
      if (edge_idx == 13) chk({tag, "_ph_c14"}, 32'(phase), 32'd1);
      if (edge_idx == 13) chk({tag, "_rm_c14"}, 32'(remaining), 32'd2);
      if (edge_idx == 13) chk({tag, "_to_c14"}, 32'(time_out), 32'd0);
    end
  endtask

  initial begin
    edge_idx = -1;
    model_reset();

    // Full cycle with a car always present
    do_reset();
    run_p0("s1");
    while (edge_idx < 57) begin
      step(1'b1, 1'b0, "s2");
      if (edge_idx == 22 || edge_idx == 44 || edge_idx == 54)
        chk("s2_to_pulse", 32'(time_out), 32'd1);
      if (edge_idx == 23) chk("s2_ph2", 32'(phase), 32'd2);
      if (edge_idx == 45) chk("s2_ph3", 32'(phase), 32'd3);
      if (edge_idx == 55) chk("s2_ph0", 32'(phase), 32'd0);
      if (edge_idx == 55) chk("s2_rem3", 32'(remaining), 32'd3);
      if (edge_idx == 55) chk("s2_req_low", 32'(sensor_req), 32'd0);
      if (edge_idx == 56) chk("s2_req_reset", 32'(sensor_req), 32'd1);
    end

    // No request: park in P0, then a single-cycle blip
    do_reset();
    while (edge_idx < 99) step(1'b0, 1'b0, "s3");
    chk("s3_no_to", 32'(saw_to), 32'd0);
    chk("s3_rem0", 32'(remaining), 32'd0);
    chk("s3_ph0", 32'(phase), 32'd0);
    step(1'b1, 1'b0, "s3");
    chk("s3_req101", 32'(sensor_req), 32'd1);
    step(1'b0, 1'b0, "s3");
    chk("s3_to102", 32'(time_out), 32'd1);
    step(1'b0, 1'b0, "s3");
    chk("s3_ph103", 32'(phase), 32'd1);

    // Hold in P2 at remaining==3, then hold on P3 expiry
    do_reset();
    while (edge_idx < 32) step(1'b1, 1'b0, "s4");
    chk("s4_rem3", 32'(remaining), 32'd3);
    chk("s4_ph2", 32'(phase), 32'd2);
    while (edge_idx < 52) step(1'b1, 1'b1, "s4h");
    chk("s4_frozen", 32'(remaining), 32'd3);
    while (edge_idx < 65) begin
      step(1'b1, 1'b0, "s4");
      if (edge_idx == 54) chk("s4_rem3_late", 32'(remaining), 32'd3);
      if (edge_idx == 55) chk("s4_rem2", 32'(remaining), 32'd2);
      if (edge_idx == 63) chk("s4_no_to_yet", 32'(time_out), 32'd0);
      if (edge_idx == 64) chk("s4_to65", 32'(time_out), 32'd1);
    end
    chk("s4_ph3", 32'(phase), 32'd3);
    while (edge_idx < 73) step(1'b1, 1'b0, "s5");
    chk("s5_rem0", 32'(remaining), 32'd0);
    while (edge_idx < 78) begin
      step(1'b1, 1'b1, "s5h");
      chk("s5_held_to", 32'(time_out), 32'd0);
    end
    step(1'b1, 1'b0, "s5");
    chk("s5_to_after_hold", 32'(time_out), 32'd1);
    step(1'b1, 1'b0, "s5");
    chk("s5_to_once", 32'(time_out), 32'd0);
    chk("s5_ph0", 32'(phase), 32'd0);

    // Async reset during a P2 tick cycle
    do_reset();
    while (edge_idx < 26) step(1'b1, 1'b0, "s6");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("s6_async_ph", 32'(phase), 32'd0);
    chk("s6_async_rem", 32'(remaining), 32'(HW_MIN_T));
    check_model("s6_async");
    repeat (2) @(posedge clk);
    #3;
    rst_n    = 1'b1;
    edge_idx = -1;
    run_p0("s6p0");

    // Random sensor/hold traffic with one asynchronous reset pulse
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0), "rnd");
      if (i == 1500) begin
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model("rnd_rst");
        @(posedge clk);
        #3;
        rst_n = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
